pll_lock_sequencer: RTL and testbench

Supervises the two-output system PLL (100 MHz reference). It pulses the PLL reset and waits for lock with a timeout, retrying a bounded number of times. It releases the downstream system reset only after lock has stayed stable for a fixed time, and re-sequences whenever lock is lost or software requests it. The block runs on the free-running PLL reference clock and sits between the board clock/reset and the PLL wrapper's `rst`/`locked` pins.

---
 rtl/pll_seq_pkg.sv | 16 +
 rtl/pll_lock_sequencer_sync_2ff.sv | 26 ++
 rtl/pll_lock_sequencer.sv | 139 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
// The state encodings are visible on state_o, so their values are fixed.
package pll_seq_pkg;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_seq_state_t;

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset, for any
// asynchronous status pins that need to be sampled in the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples its input as it was before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences the PLL reset, waits for a stable lock with bounded retries, and
// gates the downstream system reset; re-sequences on lock loss or relock_req.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 100,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 20
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               fail,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT     = '1;
  localparam longint             CNT_SPAN     = longint'(1) << CNT_W;

  if (RST_PULSE_CYCLES < 1 || longint'(RST_PULSE_CYCLES) >= CNT_SPAN) begin : g_bad_rst_pulse
    $error("RST_PULSE_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (LOCK_TIMEOUT_CYCLES < 1 || longint'(LOCK_TIMEOUT_CYCLES) >= CNT_SPAN) begin : g_bad_timeout
    $error("LOCK_TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (LOCK_STABLE_CYCLES < 1 || longint'(LOCK_STABLE_CYCLES) >= CNT_SPAN) begin : g_bad_stable
    $error("LOCK_STABLE_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("MAX_RETRIES must be in 1 .. 15");
  end

  pll_seq_state_t     state, state_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [LOSS_W-1:0]  loss_nxt;
  logic               lk;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + CNT_W'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;

    unique case (state)
      ST_RESET_PLL: begin
        if (timer == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_nxt = ST_STABILIZE;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          retry_nxt = retry_cnt + 1'b1;
          state_nxt = (retry_nxt >= RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
          timer_nxt = '0;
        end
      end
      ST_STABILIZE: begin
        // A dropout restarts the whole stability window without costing a retry.
        if (!lk) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
          retry_nxt = '0;
        end
      end
      ST_RUN: begin
        timer_nxt = '0;
        if (!lk) begin
          state_nxt = ST_RESET_PLL;
          if (loss_cnt != LOSS_SAT) loss_nxt = loss_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = (state == ST_FAIL) ? ST_FAIL : ST_RESET_PLL;
        timer_nxt = '0;
      end
    endcase

    // Software relock overrides everything, including a same-cycle lock loss.
    if (relock_req) begin
      state_nxt = ST_RESET_PLL;
      timer_nxt = '0;
      retry_nxt = '0;
      loss_nxt  = loss_cnt;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_RESET_PLL;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      pll_rst   <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
      sys_rst   <= (state_nxt != ST_RUN);
      fail      <= (state_nxt == ST_FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with
// arithmetic expectations, then randomized lock waveforms against a model.
module tb_pll_lock_sequencer;

  localparam int RST_P   = 10;
  localparam int TO_P    = 200;
  localparam int STAB_P  = 32;
  localparam int MAXR_P  = 3;
  localparam int CNTW_P  = 12;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, fail;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int passed = 0;
  int total  = 0;
  int c;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST_P),
    .LOCK_TIMEOUT_CYCLES (TO_P),
    .LOCK_STABLE_CYCLES  (STAB_P),
    .MAX_RETRIES         (MAXR_P),
    .CNT_W               (CNTW_P)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .fail       (fail),
    .state_o    (state_o),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: phase numbers follow the visible state_o codes,
  // lock is seen through a two-sample delay line.
  typedef struct packed {
    logic [2:0]  phase;
    logic [31:0] timer;
    logic [31:0] retries;
    logic [31:0] losses;
    logic        s1;
    logic        s2;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, logic locked, logic req, logic r);
    model_t n;
    logic   seen;
    n = cur;
    if (r) begin
      n = '0;
      return n;
    end
    seen = cur.s2;
    n.s2 = cur.s1;
    n.s1 = locked;
    if (req) begin
      n.phase = 3'd0; n.timer = 0; n.retries = 0;
      return n;
    end
    case (cur.phase)
      3'd0: if (cur.timer == RST_P - 1) begin n.phase = 3'd1; n.timer = 0; end
            else n.timer = cur.timer + 1;
      3'd1: if (seen) begin n.phase = 3'd2; n.timer = 0; end
            else if (cur.timer == TO_P - 1) begin
              n.retries = cur.retries + 1;
              n.phase = (n.retries >= MAXR_P) ? 3'd4 : 3'd0;
              n.timer = 0;
            end else n.timer = cur.timer + 1;
      3'd2: if (!seen) begin n.phase = 3'd1; n.timer = 0; end
            else if (cur.timer == STAB_P - 1) begin n.phase = 3'd3; n.timer = 0; n.retries = 0; end
            else n.timer = cur.timer + 1;
      3'd3: if (!seen) begin
              n.phase = 3'd0;
              n.losses = (cur.losses >= 255) ? 255 : cur.losses + 1;
            end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge refclk) m <= model_step(m, pll_locked, relock_req, rst);

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) tick();
    total++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o); else passed++;
    total++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst); else passed++;
    total++; if (sys_rst !== 1'b1) $display("FAIL reset_sys_rst: got %b want 1", sys_rst); else passed++;
    total++; if (fail !== 1'b0) $display("FAIL reset_fail: got %b want 0", fail); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt); else passed++;
    total++; if (loss_cnt !== 8'd0) $display("FAIL reset_loss: got %0d want 0", loss_cnt); else passed++;
  endtask

  task automatic test_clean_lock();
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    c = 0;
    do begin tick(); c++; end while (pll_rst === 1'b1 && c < 1000);
    total++; if (c !== RST_P) $display("FAIL pll_rst_pulse_width: got %0d want %0d", c, RST_P); else passed++;
    repeat (50) tick();
    total++; if (state_o !== 3'd1) $display("FAIL clean_wait_state: got %0d want 1", state_o); else passed++;
    pll_locked = 1'b1;
    c = 0;
    do begin tick(); c++; end while (sys_rst === 1'b1 && c < 5000);
    total++; if (c !== 2 + STAB_P + 1) $display("FAIL clean_release_latency: got %0d want %0d", c, 2 + STAB_P + 1); else passed++;
    total++; if (state_o !== 3'd3) $display("FAIL clean_run_state: got %0d want 3", state_o); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL clean_retry: got %0d want 0", retry_cnt); else passed++;
    total++; if (pll_rst !== 1'b0) $display("FAIL clean_pll_rst: got %b want 0", pll_rst); else passed++;
  endtask

  task automatic test_glitch();
    rst = 1'b1; tick(); rst = 1'b0; pll_locked = 1'b1;
    c = 0;
    while (state_o !== 3'd2 && c < 1000) begin tick(); c++; end
    repeat (STAB_P / 2) tick();
    total++; if (state_o !== 3'd2) $display("FAIL glitch_in_stabilize: got %0d want 2", state_o); else passed++;
    pll_locked = 1'b0;
    repeat (3) tick();
    total++; if (state_o !== 3'd1) $display("FAIL glitch_back_to_wait: got %0d want 1", state_o); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL glitch_no_retry: got %0d want 0", retry_cnt); else passed++;
    pll_locked = 1'b1;
    c = 3;
    do begin tick(); c++; end while (sys_rst === 1'b1 && c < 5000);
    total++; if (c !== 6 + STAB_P) $display("FAIL glitch_full_window: got %0d want %0d", c, 6 + STAB_P); else passed++;
  endtask

  task automatic test_lock_loss();
    int exp_loss = 0;
    int run_ok = 1;
    pll_locked = 1'b0;
    c = 0;
    do begin tick(); c++; end while (sys_rst === 1'b0 && c < 20);
    exp_loss++;
    total++; if (c !== 3) $display("FAIL loss_sys_rst_latency: got %0d want 3", c); else passed++;
    total++; if (loss_cnt !== 8'(exp_loss)) $display("FAIL loss_count_first: got %0d want %0d", loss_cnt, exp_loss); else passed++;
    total++; if (state_o !== 3'd0) $display("FAIL loss_to_reset_pll: got %0d want 0", state_o); else passed++;
    c = 0;
    while (pll_rst === 1'b1 && c < 1000) begin tick(); c++; end
    total++; if (c !== RST_P) $display("FAIL loss_pll_rst_pulse: got %0d want %0d", c, RST_P); else passed++;
    for (int k = 1; k < 300; k++) begin
      pll_locked = 1'b1;
      c = 0;
      while (state_o !== 3'd3 && c < 500) begin tick(); c++; end
      if (state_o !== 3'd3) run_ok = 0;
      pll_locked = 1'b0;
      c = 0;
      while (sys_rst !== 1'b1 && c < 20) begin tick(); c++; end
      exp_loss = (exp_loss >= 255) ? 255 : exp_loss + 1;
    end
    total++; if (run_ok !== 1) $display("FAIL loss_loop_reached_run: got %0d want 1", run_ok); else passed++;
    total++; if (loss_cnt !== 8'(exp_loss)) $display("FAIL loss_saturated: got %0d want %0d", loss_cnt, exp_loss); else passed++;
  endtask

  task automatic test_never_lock();
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    c = 0;
    do begin tick(); c++; end while (fail !== 1'b1 && c < MAXR_P * (RST_P + TO_P) + 100);
    total++; if (c !== MAXR_P * (RST_P + TO_P)) $display("FAIL never_lock_time: got %0d want %0d", c, MAXR_P * (RST_P + TO_P)); else passed++;
    total++; if (state_o !== 3'd4) $display("FAIL never_lock_state: got %0d want 4", state_o); else passed++;
    total++; if (retry_cnt !== 4'(MAXR_P)) $display("FAIL never_lock_retry: got %0d want %0d", retry_cnt, MAXR_P); else passed++;
    total++; if (sys_rst !== 1'b1 || pll_rst !== 1'b1) $display("FAIL never_lock_resets: got %b%b want 11", sys_rst, pll_rst); else passed++;
    pll_locked = 1'b1;
    repeat (50) tick();
    total++; if (state_o !== 3'd4 || fail !== 1'b1) $display("FAIL fail_sticky: got state %0d fail %b want 4 1", state_o, fail); else passed++;
  endtask

  task automatic test_recover_from_fail();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    total++; if (fail !== 1'b0) $display("FAIL recover_fail_clear: got %b want 0", fail); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL recover_retry_clear: got %0d want 0", retry_cnt); else passed++;
    total++; if (state_o !== 3'd0 || pll_rst !== 1'b1) $display("FAIL recover_state: got %0d/%b want 0/1", state_o, pll_rst); else passed++;
    c = 0;
    do begin tick(); c++; end while (state_o !== 3'd3 && c < 1000);
    total++; if (c !== RST_P + 1 + STAB_P) $display("FAIL recover_to_run: got %0d want %0d", c, RST_P + 1 + STAB_P); else passed++;
  endtask

  task automatic test_simultaneous();
    pll_locked = 1'b0;
    c = 0;
    while (sys_rst !== 1'b1 && c < 20) begin tick(); c++; end
    total++; if (loss_cnt !== 8'd1) $display("FAIL simul_first_loss: got %0d want 1", loss_cnt); else passed++;
    pll_locked = 1'b1;
    c = 0;
    while (state_o !== 3'd3 && c < 500) begin tick(); c++; end
    pll_locked = 1'b0;
    tick(); tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    total++; if (state_o !== 3'd0 || sys_rst !== 1'b1) $display("FAIL simul_state: got %0d/%b want 0/1", state_o, sys_rst); else passed++;
    total++; if (loss_cnt !== 8'd1) $display("FAIL simul_relock_wins: got %0d want 1", loss_cnt); else passed++;
    pll_locked = 1'b1;
    c = 0;
    while (state_o !== 3'd2 && c < 500) begin tick(); c++; end
    repeat (5) tick();
    rst = 1'b1; tick();
    total++; if (state_o !== 3'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || fail !== 1'b0)
      $display("FAIL rst_mid_stab_outputs: got %0d %b %b %b want 0 1 1 0", state_o, pll_rst, sys_rst, fail); else passed++;
    total++; if (loss_cnt !== 8'd0 || retry_cnt !== 4'd0)
      $display("FAIL rst_mid_stab_counters: got %0d %0d want 0 0", loss_cnt, retry_cnt); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_random();
    int flip_div = 15;
    int errs = 0;
    logic [16:0] got, want;
    pll_locked = 1'b0; relock_req = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      got  = {state_o, pll_rst, sys_rst, fail, retry_cnt, loss_cnt};
      want = {m.phase, (m.phase == 3'd0 || m.phase == 3'd4), (m.phase != 3'd3), (m.phase == 3'd4),
              m.retries[3:0], m.losses[7:0]};
      total++;
      if (got !== want) begin
        if (errs < 10) $display("FAIL random_cycle_%0d: got %h want %h", i, got, want);
        errs++;
      end else passed++;
      if (i % 400 == 0) flip_div = ($urandom_range(0, 1) == 1) ? 300 : 15;
      if ($urandom_range(0, flip_div - 1) == 0) pll_locked = ~pll_locked;
      relock_req = ($urandom_range(0, 399) == 0);
      rst        = ($urandom_range(0, 1999) == 0);
    end
    rst = 1'b0; relock_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_lock_loss();
    test_never_lock();
    test_recover_from_fail();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
